// File: rtl/execute_cycle_if.sv
// Execute-stage bus: E-stage operands/control in, forwarding selects in,
// redirect request and registered M-stage fields out.
interface execute_cycle_if;
    // E-stage control from the decode pipeline register
    logic        RegWriteE;
    logic        ALUSrcE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic        jumpE;
    logic [2:0]  ALUControlE;
    // E-stage operands
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RD_E;
    // Forwarding
    logic [31:0] ResultW;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    // Redirect to fetch
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    // M-stage register outputs
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    // The execute block itself
    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, jumpE,
        input  ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
        input  ResultW, ForwardA_E, ForwardB_E,
        output PCSrcE, PCTargetE,
        output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );

    // The decode side driving the execute block
    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, jumpE,
        output ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
        output ResultW, ForwardA_E, ForwardB_E,
        input  PCSrcE, PCTargetE,
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage of a 5-stage RISC-V style pipeline: operand forwarding,
// ALU, branch/jump resolution and the E->M pipeline register.
module execute_cycle (
    input  logic      clk,
    input  logic      rst,
    execute_cycle_if.slave bus
);
    localparam int DATA_W = 32;

    // Forwarding mux: 01 takes writeback, 10 takes the registered M result.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] mem_val
    );
        logic [DATA_W-1:0] r;
        case (sel)
            2'b01:   r = wb_val;
            2'b10:   r = mem_val;
            default: r = reg_val;
        endcase
        return r;
    endfunction

    // ALU; operands are signed so set-less-than compares as two's complement.
    function automatic logic [DATA_W-1:0] alu_op(
        input logic [2:0]               ctl,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (ctl)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r = (a < b) ? DATA_W'(1) : DATA_W'(0);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic              reg_write_q,   reg_write_d;
    logic              mem_write_q,   mem_write_d;
    logic              result_src_q,  result_src_d;
    logic [4:0]        rd_q,          rd_d;
    logic [DATA_W-1:0] pc_plus4_q,    pc_plus4_d;
    logic [DATA_W-1:0] write_data_q,  write_data_d;
    logic [DATA_W-1:0] alu_result_q,  alu_result_d;

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b_fwd;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              zero_e;
    logic              pc_src;
    logic [DATA_W-1:0] pc_target;

    // Operand selection, ALU, redirect decision and next M-register contents.
    always_comb begin
        src_a     = fwd_sel(bus.ForwardA_E, bus.RD1_E, bus.ResultW, alu_result_q);
        src_b_fwd = fwd_sel(bus.ForwardB_E, bus.RD2_E, bus.ResultW, alu_result_q);
        alu_b     = bus.ALUSrcE ? bus.Imm_Ext_E : src_b_fwd;
        alu_result = alu_op(bus.ALUControlE, src_a, alu_b);
        zero_e    = (alu_result == '0);
        pc_target = bus.PCE + bus.Imm_Ext_E;
        pc_src    = (bus.BranchE & zero_e) | bus.jumpE;

        reg_write_d  = bus.RegWriteE;
        mem_write_d  = bus.MemWriteE;
        result_src_d = bus.ResultSrcE;
        rd_d         = bus.RD_E;
        pc_plus4_d   = bus.PCPlus4E;
        // Store data is always the forwarded register, never the immediate.
        write_data_d = src_b_fwd;
        // Jumps carry the link address in the ALU slot so writeback needs no extra mux.
        alu_result_d = bus.jumpE ? bus.PCPlus4E : alu_result;
    end

    // E->M pipeline register; async reset clears control and data alike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            write_data_q <= '0;
            alu_result_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            write_data_q <= write_data_d;
            alu_result_q <= alu_result_d;
        end
    end

    assign bus.PCSrcE      = pc_src;
    assign bus.PCTargetE   = pc_target;
    assign bus.RegWriteM   = reg_write_q;
    assign bus.MemWriteM   = mem_write_q;
    assign bus.ResultSrcM  = result_src_q;
    assign bus.RD_M        = rd_q;
    assign bus.PCPlus4M    = pc_plus4_q;
    assign bus.WriteDataM  = write_data_q;
    assign bus.ALU_ResultM = alu_result_q;
endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle with a scoreboard of expected M-register contents.
module tb_execute_cycle;
    logic clk;
    logic rst;

    execute_cycle_if bus();

    execute_cycle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] alu;
    } m_t;

    m_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic m_t observed_m();
        m_t o;
        o.rw  = bus.RegWriteM;
        o.mw  = bus.MemWriteM;
        o.rs  = bus.ResultSrcM;
        o.rd  = bus.RD_M;
        o.pc4 = bus.PCPlus4M;
        o.wd  = bus.WriteDataM;
        o.alu = bus.ALU_ResultM;
        return o;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        m_t o;
        o = observed_m();
        checks++;
        assert (o === '0) else begin
            errors++;
            $error("FAIL %s observed=%h expected=0", tag, o);
        end
    endtask

    task automatic push(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                        input logic [31:0] pc4, input logic [31:0] wd, input logic [31:0] alu);
        m_t e;
        e.rw = rw; e.mw = mw; e.rs = rs; e.rd = rd;
        e.pc4 = pc4; e.wd = wd; e.alu = alu;
        exp_q.push_back(e);
    endtask

    // One clock edge, then compare the M register with the oldest expectation.
    task automatic step(input string tag);
        m_t e;
        m_t o;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=output expected=no pending entry", tag);
        end else begin
            e = exp_q.pop_front();
            o = observed_m();
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    task automatic bubble();
        bus.RegWriteE   = 1'b0;
        bus.ALUSrcE     = 1'b0;
        bus.MemWriteE   = 1'b0;
        bus.ResultSrcE  = 1'b0;
        bus.BranchE     = 1'b0;
        bus.jumpE       = 1'b0;
        bus.ALUControlE = 3'b000;
        bus.RD1_E       = '0;
        bus.RD2_E       = '0;
        bus.Imm_Ext_E   = '0;
        bus.PCE         = '0;
        bus.PCPlus4E    = '0;
        bus.RD_E        = '0;
        bus.ResultW     = '0;
        bus.ForwardA_E  = 2'b00;
        bus.ForwardB_E  = 2'b00;
    endtask

    logic [2:0]  logic_ctl [5];
    logic [31:0] logic_exp [5];

    initial begin
        logic_ctl = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
        logic_exp = '{32'h0000_F000, 32'h0000_FFF0, 32'h0, 32'h0, 32'h0};

        rst = 1'b0;
        bubble();
        bus.RegWriteE = 1'b1;
        bus.RD1_E     = 32'd5;
        bus.PCPlus4E  = 32'd4;
        bus.RD_E      = 5'd2;
        #1 rst = 1'b1;
        #1 chk_zero("reset_async_initial");

        // Registers hold zero across edges while reset is high; redirect still live.
        bus.PCE       = 32'h10;
        bus.Imm_Ext_E = 32'h8;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_hold");
        chk32("target_in_reset", bus.PCTargetE, 32'h18);

        @(negedge clk) rst = 1'b0;

        // add
        bubble();
        bus.RD1_E = 32'd5; bus.RD2_E = 32'd7; bus.RD_E = 5'd3;
        bus.RegWriteE = 1'b1; bus.PCPlus4E = 32'h104;
        push(1'b1, 1'b0, 1'b0, 5'd3, 32'h104, 32'd7, 32'd12);
        step("add");

        // back-to-back dependency on the M result
        bubble();
        bus.ForwardA_E = 2'b10; bus.RD1_E = 32'd0; bus.RD2_E = 32'd3;
        bus.RD_E = 5'd4; bus.RegWriteE = 1'b1;
        push(1'b1, 1'b0, 1'b0, 5'd4, 32'h0, 32'd3, 32'd15);
        step("fwd_a_mem");

        // store data forwarded from writeback, address uses the immediate
        bubble();
        bus.ForwardB_E = 2'b01; bus.ResultW = 32'h40; bus.ALUSrcE = 1'b1;
        bus.Imm_Ext_E = 32'd4; bus.MemWriteE = 1'b1;
        bus.RD1_E = 32'h100; bus.RD2_E = 32'h999;
        push(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h40, 32'h104);
        step("fwd_b_wb_store");

        // signed set-less-than both ways
        bubble();
        bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1; bus.ALUControlE = 3'b101;
        bus.RD_E = 5'd5; bus.RegWriteE = 1'b1;
        push(1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'd1, 32'd1);
        step("slt_neg_lt_pos");

        bus.RD1_E = 32'd1; bus.RD2_E = 32'hFFFF_FFFF;
        push(1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'hFFFF_FFFF, 32'd0);
        step("slt_pos_lt_neg");

        // sub with wraparound, ResultSrc carried
        bubble();
        bus.RD1_E = 32'd5; bus.RD2_E = 32'd7; bus.ALUControlE = 3'b001;
        bus.RD_E = 5'd6; bus.RegWriteE = 1'b1; bus.ResultSrcE = 1'b1;
        push(1'b1, 1'b0, 1'b1, 5'd6, 32'h0, 32'd7, 32'hFFFF_FFFE);
        step("sub_wrap");

        // and / or / unused encodings
        for (int i = 0; i < 5; i++) begin
            bubble();
            bus.RD1_E = 32'h0000_F0F0; bus.RD2_E = 32'h0000_FF00;
            bus.ALUControlE = logic_ctl[i];
            push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_FF00, logic_exp[i]);
            step($sformatf("logic_op_%0d", logic_ctl[i]));
        end

        // beq taken
        bubble();
        bus.RD1_E = 32'd9; bus.RD2_E = 32'd9; bus.ALUControlE = 3'b001;
        bus.BranchE = 1'b1; bus.PCE = 32'h100; bus.Imm_Ext_E = 32'h20;
        #1;
        chk32("beq_taken_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        chk32("beq_target", bus.PCTargetE, 32'h120);
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd9, 32'd0);
        step("beq_taken_m");

        // beq not taken
        bus.RD2_E = 32'd8;
        #1;
        chk32("beq_not_taken_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'd8, 32'd1);
        step("beq_not_taken_m");

        // jal with target wrap; link value goes through the ALU slot
        bubble();
        bus.jumpE = 1'b1; bus.PCE = 32'hFFFF_FFF0; bus.Imm_Ext_E = 32'h20;
        bus.PCPlus4E = 32'hFFFF_FFF4; bus.RegWriteE = 1'b1; bus.RD_E = 5'd1;
        bus.RD1_E = 32'd3; bus.RD2_E = 32'h55;
        #1;
        chk32("jal_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        chk32("jal_target_wrap", bus.PCTargetE, 32'h10);
        push(1'b1, 1'b0, 1'b0, 5'd1, 32'hFFFF_FFF4, 32'h55, 32'hFFFF_FFF4);
        step("jal_link");

        // branch and jump together with nonzero ALU result
        bubble();
        bus.BranchE = 1'b1; bus.jumpE = 1'b1; bus.RD1_E = 32'd1; bus.RD2_E = 32'd2;
        bus.ALUControlE = 3'b001; bus.PCPlus4E = 32'h20;
        #1;
        chk32("branch_and_jump_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h20, 32'd2, 32'h20);
        step("branch_and_jump_m");

        // select 11 falls back to the register; B forwarded from M (0x20)
        bubble();
        bus.ForwardA_E = 2'b11; bus.RD1_E = 32'h30; bus.ResultW = 32'h777;
        bus.ForwardB_E = 2'b10; bus.RD2_E = 32'h5;
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h20, 32'h50);
        step("fwd_a11_b_mem");

        // reset mid-operation
        bubble();
        bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.ResultSrcE = 1'b1;
        bus.RD_E = 5'd9; bus.PCPlus4E = 32'h44; bus.RD1_E = 32'd1; bus.RD2_E = 32'd2;
        push(1'b1, 1'b1, 1'b1, 5'd9, 32'h44, 32'd2, 32'd3);
        step("pre_reset");

        bus.PCE = 32'h200; bus.Imm_Ext_E = 32'h10;
        #2 rst = 1'b1;
        #1;
        chk_zero("reset_async_midop");
        chk32("target_during_reset", bus.PCTargetE, 32'h210);
        @(posedge clk);
        #1;
        chk_zero("reset_hold_edge");

        @(negedge clk) rst = 1'b0;
        bubble();
        bus.ForwardA_E = 2'b10; bus.RD1_E = 32'hDEAD; bus.RD2_E = 32'h11;
        bus.RD_E = 5'd7; bus.RegWriteE = 1'b1;
        push(1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 32'h11, 32'h11);
        step("post_reset_fwd_zero");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
